// File: rtl/tl_debug_mailbox.sv
// TileLink-UL debug/test mailbox: state registers, sticky exit register,
// console byte FIFO with valid/ready drain and a 64-bit cycle counter whose
// high half is snapshotted on every low-half read so that a LO-then-HI read
// pair is coherent.
//
// Handshake: a beat moves on the A channel when a_valid & a_ready, and on
// the D channel when d_valid & d_ready. Only one request is ever outstanding
// (a_ready = !d_valid). The response appears the cycle after acceptance and
// holds every d_* field until it is taken. a_ready returns the cycle after
// that, so a response slot is never refilled in the same cycle it drains.
module tl_debug_mailbox #(
  parameter int TL_SOURCE_W   = 1,
  parameter int STATE_WORDS   = 4,
  parameter int CONSOLE_DEPTH = 8,
  parameter int ADDR_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               a_opcode,
  input  logic [2:0]               a_param,
  input  logic [3:0]               a_size,
  input  logic [TL_SOURCE_W-1:0]   a_source,
  input  logic [ADDR_W-1:0]        a_address,
  input  logic [3:0]               a_mask,
  input  logic [31:0]              a_data,
  input  logic                     a_corrupt,
  input  logic                     a_valid,
  output logic                     a_ready,
  output logic [2:0]               d_opcode,
  output logic [1:0]               d_param,
  output logic [3:0]               d_size,
  output logic [TL_SOURCE_W-1:0]   d_source,
  output logic                     d_denied,
  output logic [31:0]              d_data,
  output logic                     d_corrupt,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [7:0]               con_data,
  output logic                     con_valid,
  input  logic                     con_ready,
  output logic                     callenv,
  output logic [31:0]              exit_code,
  output logic [32*STATE_WORDS-1:0] state_o
);

  localparam int PTR_W = $clog2(CONSOLE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Request decode
  logic        accept;
  logic        is_get;
  logic        is_put;
  logic        size_bad;
  logic [7:0]  off;
  logic [5:0]  word_idx;
  logic [31:0] wmask;

  assign accept   = a_valid & a_ready;
  assign is_get   = (a_opcode == 3'd4);
  assign is_put   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign size_bad = (a_size > 4'd2);
  assign off      = a_address[7:0];
  assign word_idx = off[7:2];
  assign wmask    = {{8{a_mask[3]}}, {8{a_mask[2]}}, {8{a_mask[1]}}, {8{a_mask[0]}}};

  // Only the low address byte is decoded; parameter and corrupt bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{a_param, a_corrupt, a_address[ADDR_W-1:8]};

  // Storage
  logic [31:0]            state_q [STATE_WORDS];
  logic [63:0]            cycle_q;
  logic [31:0]            hi_snap_q;
  logic [7:0]             fifo_mem [CONSOLE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   pop;

  assign con_valid = (count != '0);
  assign full      = (count == CNT_W'(CONSOLE_DEPTH));
  assign con_data  = fifo_mem[rd_ptr];
  assign pop       = con_valid & con_ready;
  assign a_ready   = !d_valid;
  assign d_param   = 2'b00;

  // Export state registers as one flat vector
  for (genvar g = 0; g < STATE_WORDS; g++) begin : g_state_o
    assign state_o[32*g +: 32] = state_q[g];
  end

  // State register window: 0x10 + 4*i, word-aligned, i < STATE_WORDS
  logic                   state_hit;
  logic [31:0]            state_rd;
  logic [STATE_WORDS-1:0] state_sel;

  // Select the addressed state word, if any
  always_comb begin
    state_hit = 1'b0;
    state_rd  = '0;
    state_sel = '0;
    for (int i = 0; i < STATE_WORDS; i++) begin
      if (off[1:0] == 2'b00 && word_idx == 6'(i + 4)) begin
        state_hit    = 1'b1;
        state_rd     = state_q[i];
        state_sel[i] = 1'b1;
      end
    end
  end

  // Response and side-effect decode for the beat on the A channel
  logic                   rsp_denied;
  logic [31:0]            rsp_data;
  logic                   exit_we;
  logic                   push_req;
  logic                   snap_we;
  logic [STATE_WORDS-1:0] state_we;

  // Address map; anything unrecognised is denied with no side effect
  always_comb begin
    rsp_denied = 1'b0;
    rsp_data   = '0;
    exit_we    = 1'b0;
    push_req   = 1'b0;
    snap_we    = 1'b0;
    state_we   = '0;
    if (!(is_get || is_put) || size_bad) begin
      rsp_denied = 1'b1;
    end else begin
      case (off)
        8'h00: begin
          if (is_get) rsp_data = exit_code;
          else        exit_we  = 1'b1;
        end
        8'h04: begin
          if (is_get) begin
            rsp_data = {16'(count), 15'b0, full};
          end else if (a_mask[0]) begin
            // A full FIFO still takes the byte if the head leaves this cycle
            if (full && !pop) rsp_denied = 1'b1;
            else              push_req   = 1'b1;
          end
        end
        8'h08: begin
          if (is_get) begin
            rsp_data = cycle_q[31:0];
            snap_we  = 1'b1;
          end else begin
            rsp_denied = 1'b1;
          end
        end
        8'h0C: begin
          if (is_get) rsp_data   = hi_snap_q;
          else        rsp_denied = 1'b1;
        end
        default: begin
          if (!state_hit)  rsp_denied = 1'b1;
          else if (is_get) rsp_data   = state_rd;
          else             state_we   = state_sel;
        end
      endcase
    end
  end

  // D channel response register: load on accept, clear on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 4'd0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= '0;
      d_corrupt <= 1'b0;
    end else if (accept) begin
      d_valid   <= 1'b1;
      d_opcode  <= is_get ? 3'd1 : 3'd0;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= rsp_denied;
      d_data    <= rsp_denied ? 32'd0 : rsp_data;
      d_corrupt <= is_get & rsp_denied;
    end else if (d_ready) begin
      d_valid   <= 1'b0;
    end
  end

  // Sticky exit register: only the first non-empty write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      callenv   <= 1'b0;
      exit_code <= '0;
    end else if (accept && exit_we && !callenv && a_mask != 4'b0000) begin
      callenv   <= 1'b1;
      exit_code <= a_data & wmask;
    end
  end

  // State registers with per-byte write enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATE_WORDS; i++) state_q[i] <= '0;
    end else begin
      for (int i = 0; i < STATE_WORDS; i++) begin
        if (accept && state_we[i]) state_q[i] <= (state_q[i] & ~wmask) | (a_data & wmask);
      end
    end
  end

  // Console FIFO: registered storage, power-of-two pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CONSOLE_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept && push_req) begin
        fifo_mem[wr_ptr] <= a_data[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if ((accept && push_req) && !pop)      count <= count + 1'b1;
      else if (!(accept && push_req) && pop) count <= count - 1'b1;
    end
  end

  // Free-running cycle counter and high-half snapshot taken on LO reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      hi_snap_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (accept && snap_we) hi_snap_q <= cycle_q[63:32];
    end
  end

endmodule

// File: tb/tb_tl_debug_mailbox.sv
// Bench for tl_debug_mailbox: directed scenarios plus a randomized run,
// all checked against a register/queue level reference model.
module tb_tl_debug_mailbox;

  localparam int SW    = 4;
  localparam int DEPTH = 8;

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        a_opcode = '0;
  logic [2:0]        a_param = '0;
  logic [3:0]        a_size = '0;
  logic [0:0]        a_source = '0;
  logic [31:0]       a_address = '0;
  logic [3:0]        a_mask = '0;
  logic [31:0]       a_data = '0;
  logic              a_corrupt = 1'b0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [3:0]        d_size;
  logic [0:0]        d_source;
  logic              d_denied;
  logic [31:0]       d_data;
  logic              d_corrupt;
  logic              d_valid;
  logic              d_ready = 1'b0;
  logic [7:0]        con_data;
  logic              con_valid;
  logic              con_ready = 1'b0;
  logic              callenv;
  logic [31:0]       exit_code;
  logic [32*SW-1:0]  state_o;

  tl_debug_mailbox #(
    .TL_SOURCE_W(1), .STATE_WORDS(SW), .CONSOLE_DEPTH(DEPTH), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid),
    .d_ready(d_ready),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .callenv(callenv), .exit_code(exit_code), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_state [SW];
  logic        m_callenv;
  logic [31:0] m_exit;
  logic [31:0] m_snap;
  logic [7:0]  exp_q[$];
  logic [63:0] tb_cycles = '0;
  logic [63:0] cnt_base = '0;
  logic [63:0] cnt_mark = '0;

  always @(posedge clk) if (rst_n) tb_cycles <= tb_cycles + 64'd1;

  function automatic logic [63:0] cnt_now();
    return cnt_base + (tb_cycles - cnt_mark);
  endfunction

  function automatic logic [32*SW-1:0] exp_state_o();
    logic [32*SW-1:0] v;
    for (int i = 0; i < SW; i++) v[32*i +: 32] = m_state[i];
    return v;
  endfunction

  // Expected and observed response of the last transaction
  logic [2:0]  exp_op;
  logic        exp_den;
  logic [31:0] exp_data;
  logic        exp_cor;
  logic [3:0]  exp_size;
  logic [0:0]  exp_src;
  logic [63:0] exp_cnt;
  logic [2:0]  rsp_op;
  logic        rsp_den;
  logic [31:0] rsp_data;
  logic        rsp_cor;
  logic [3:0]  rsp_size;
  logic [0:0]  rsp_src;

  task automatic model_reset();
    for (int i = 0; i < SW; i++) m_state[i] = '0;
    m_callenv = 1'b0;
    m_exit    = '0;
    m_snap    = '0;
    exp_q.delete();
  endtask

  // Apply one accepted request to the model; pop = head leaves the FIFO this cycle
  task automatic model_txn(input logic [2:0] op, input logic [7:0] off, input logic [31:0] data,
                           input logic [3:0] mask, input logic [3:0] size, input bit pop);
    logic [31:0] bm;
    bit          get, put, do_push;
    int          idx;
    bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    get = (op == 3'd4);
    put = (op == 3'd0) || (op == 3'd1);
    exp_op   = get ? 3'd1 : 3'd0;
    exp_den  = 1'b0;
    exp_data = '0;
    exp_cnt  = cnt_now();
    do_push  = 1'b0;
    idx      = (int'(off) - 16) / 4;
    if (!(get || put) || size > 4'd2) begin
      exp_den = 1'b1;
    end else if (off == 8'h00) begin
      if (get) exp_data = m_exit;
      else if (!m_callenv && mask != 4'b0000) begin
        m_callenv = 1'b1;
        m_exit    = data & bm;
      end
    end else if (off == 8'h04) begin
      if (get) exp_data = {16'(exp_q.size()), 15'b0, exp_q.size() == DEPTH};
      else if (mask[0]) begin
        if (exp_q.size() == DEPTH && !pop) exp_den = 1'b1;
        else do_push = 1'b1;
      end
    end else if (off == 8'h08) begin
      if (get) begin
        exp_data = exp_cnt[31:0];
        m_snap   = exp_cnt[63:32];
      end else exp_den = 1'b1;
    end else if (off == 8'h0C) begin
      if (get) exp_data = m_snap;
      else exp_den = 1'b1;
    end else if (off >= 8'h10 && off[1:0] == 2'b00 && idx < SW) begin
      if (get) exp_data = m_state[idx];
      else m_state[idx] = (m_state[idx] & ~bm) | (data & bm);
    end else begin
      exp_den = 1'b1;
    end
    exp_cor = get && exp_den;
    if (pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(data[7:0]);
  endtask

  // Driver: one full A/D transaction; returns at the negedge after the D handshake
  task automatic tl_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [3:0] size, input bit pop_now);
    int n;
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    if (!a_ready) begin
      checks++; errors++;
      $display("FAIL a_ready_timeout: a_ready=%0b required 1", a_ready);
    end
    a_opcode  = op;
    a_address = addr;
    a_data    = data;
    a_mask    = mask;
    a_size    = size;
    a_source  = 1'($urandom_range(0, 1));
    a_valid   = 1'b1;
    exp_size  = size;
    exp_src   = a_source;
    if (pop_now) con_ready = 1'b1;
    model_txn(op, addr[7:0], data, mask, size, pop_now && exp_q.size() > 0);
    @(posedge clk); #1;
    a_valid   = 1'b0;
    con_ready = 1'b0;
    @(negedge clk);
    n = 0;
    while (!d_valid && n < 20) begin @(negedge clk); n++; end
    if (!d_valid) begin
      checks++; errors++;
      $display("FAIL d_valid_timeout: d_valid=%0b required 1", d_valid);
    end
    rsp_op   = d_opcode;
    rsp_den  = d_denied;
    rsp_data = d_data;
    rsp_cor  = d_corrupt;
    rsp_size = d_size;
    rsp_src  = d_source;
    d_ready  = 1'b1;
    @(negedge clk);
    d_ready  = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({d_valid, a_ready, callenv, exit_code, con_valid, state_o} !== {1'b0, 1'b1, 1'b0, 32'd0, 1'b0, {32*SW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_outputs: d_valid=%0b a_ready=%0b callenv=%0b exit=%h con_valid=%0b state=%h required 0 1 0 0 0 0",
               d_valid, a_ready, callenv, exit_code, con_valid, state_o);
    end
    checks++;
    if ({d_opcode, d_param, d_size, d_denied, d_data, d_corrupt} !== '0) begin
      errors++;
      $display("FAIL reset_d_fields: op=%0d param=%0d size=%0d den=%0b data=%h cor=%0b required all 0",
               d_opcode, d_param, d_size, d_denied, d_data, d_corrupt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_state_regs();
    tl_txn(3'd4, 32'h0000_0010, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if ({rsp_op, rsp_den, rsp_data, rsp_cor} !== {3'd1, 1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL get_state0: op=%0d den=%0b data=%h cor=%0b required 1 0 00000000 0", rsp_op, rsp_den, rsp_data, rsp_cor);
    end
    tl_txn(3'd0, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 4'd2, 1'b0);
    checks++;
    if ({rsp_op, rsp_den, state_o[63:32]} !== {3'd0, 1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL putfull_state1: op=%0d den=%0b state1=%h required 0 0 deadbeef", rsp_op, rsp_den, state_o[63:32]);
    end
    tl_txn(3'd1, 32'h0000_0014, 32'h0000_00AA, 4'b0001, 4'd2, 1'b0);
    checks++;
    if (state_o[63:32] !== 32'hDEAD_BEAA) begin
      errors++;
      $display("FAIL putpartial_state1: state1=%h required deadbeaa", state_o[63:32]);
    end
    tl_txn(3'd4, 32'h0000_0040, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if ({rsp_op, rsp_den, rsp_data, rsp_cor} !== {3'd1, 1'b1, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL get_unmapped: op=%0d den=%0b data=%h cor=%0b required 1 1 00000000 1", rsp_op, rsp_den, rsp_data, rsp_cor);
    end
    // Oversized write must be denied and leave STATE[2] untouched
    tl_txn(3'd0, 32'h0000_0018, 32'h1234_5678, 4'hF, 4'd3, 1'b0);
    checks++;
    if ({rsp_op, rsp_den, rsp_cor, state_o[95:64]} !== {3'd0, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL size3_put: op=%0d den=%0b cor=%0b state2=%h required 0 1 0 00000000", rsp_op, rsp_den, rsp_cor, state_o[95:64]);
    end
  endtask

  task automatic test_console();
    logic [7:0] e;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      tl_txn(3'd0, 32'h0000_0004, 32'h41 + i, 4'h1, 4'd0, 1'b0);
      checks++;
      if (rsp_den !== 1'b0) begin
        errors++;
        $display("FAIL con_push_%0d: den=%0b required 0", i, rsp_den);
      end
    end
    tl_txn(3'd0, 32'h0000_0004, 32'h5A, 4'h1, 4'd0, 1'b0);
    checks++;
    if (rsp_den !== 1'b1) begin
      errors++;
      $display("FAIL con_push_full: den=%0b required 1", rsp_den);
    end
    tl_txn(3'd4, 32'h0000_0004, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if (rsp_data !== 32'h0008_0001) begin
      errors++;
      $display("FAIL con_status_full: data=%h required 00080001", rsp_data);
    end
    // Push into a full FIFO while the head drains in the same cycle
    checks++;
    if (con_data !== 8'h41) begin
      errors++;
      $display("FAIL con_head: data=%h required 41", con_data);
    end
    tl_txn(3'd0, 32'h0000_0004, 32'h49, 4'h1, 4'd0, 1'b1);
    checks++;
    if (rsp_den !== 1'b0) begin
      errors++;
      $display("FAIL con_push_pop_full: den=%0b required 0", rsp_den);
    end
    tl_txn(3'd4, 32'h0000_0004, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if (rsp_data !== exp_data || rsp_data !== 32'h0008_0001) begin
      errors++;
      $display("FAIL con_status_after: data=%h required %h", rsp_data, exp_data);
    end
    con_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      if (con_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (con_data !== e) begin
          errors++;
          $display("FAIL con_drain: data=%h required %h", con_data, e);
        end
      end
      @(negedge clk);
      n++;
    end
    con_ready = 1'b0;
    checks++;
    if (con_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL con_drain_end: con_valid=%0b left=%0d required 0 0", con_valid, exp_q.size());
    end
  endtask

  task automatic test_exit();
    tl_txn(3'd0, 32'h0000_0000, 32'h1, 4'hF, 4'd2, 1'b0);
    checks++;
    if ({rsp_den, callenv, exit_code} !== {1'b0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL exit_first: den=%0b callenv=%0b exit=%h required 0 1 00000001", rsp_den, callenv, exit_code);
    end
    tl_txn(3'd0, 32'h0000_0000, 32'h2, 4'hF, 4'd2, 1'b0);
    checks++;
    if ({callenv, exit_code} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL exit_sticky: callenv=%0b exit=%h required 1 00000001", callenv, exit_code);
    end
    tl_txn(3'd4, 32'h0000_0000, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if (rsp_data !== 32'd1) begin
      errors++;
      $display("FAIL exit_read: data=%h required 00000001", rsp_data);
    end
  endtask

  task automatic test_backpressure();
    logic [0:0] src;
    a_opcode  = 3'd4;
    a_address = 32'h0000_0014;
    a_size    = 4'd2;
    a_mask    = 4'hF;
    src       = 1'($urandom_range(0, 1));
    a_source  = src;
    a_valid   = 1'b1;
    model_txn(3'd4, 8'h14, 32'h0, 4'hF, 4'd2, 1'b0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({d_valid, a_ready, d_opcode, d_denied, d_data, d_source} !== {1'b1, 1'b0, 3'd1, 1'b0, 32'hDEAD_BEAA, src}) begin
        errors++;
        $display("FAIL stall_hold_%0d: v=%0b rdy=%0b op=%0d den=%0b data=%h src=%0d required 1 0 1 0 deadbeaa %0d",
                 i, d_valid, a_ready, d_opcode, d_denied, d_data, d_source, src);
      end
    end
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    checks++;
    if ({d_valid, a_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_release: d_valid=%0b a_ready=%0b required 0 1", d_valid, a_ready);
    end
  endtask

  task automatic force_counter(input logic [63:0] v);
    force dut.cycle_q = v;
    #1;
    release dut.cycle_q;
    cnt_base = v;
    cnt_mark = tb_cycles;
  endtask

  task automatic test_counter();
    logic [63:0] c;
    @(negedge clk);
    force_counter(64'h0000_0000_FFFF_FFFF);
    tl_txn(3'd4, 32'h0000_0008, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if (rsp_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL cnt_lo_force: data=%h required ffffffff", rsp_data);
    end
    tl_txn(3'd4, 32'h0000_000C, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if (rsp_data !== 32'd0) begin
      errors++;
      $display("FAIL cnt_hi_snapshot: data=%h required 00000000", rsp_data);
    end
    tl_txn(3'd4, 32'h0000_0008, 32'h0, 4'hF, 4'd2, 1'b0);
    c = exp_cnt;
    checks++;
    if (rsp_data !== c[31:0]) begin
      errors++;
      $display("FAIL cnt_lo_next: data=%h required %h", rsp_data, c[31:0]);
    end
    tl_txn(3'd4, 32'h0000_000C, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if (rsp_data !== 32'd1) begin
      errors++;
      $display("FAIL cnt_hi_next: data=%h required 00000001", rsp_data);
    end
    // Wrap from all ones back to zero
    @(negedge clk);
    force_counter(64'hFFFF_FFFF_FFFF_FFFF);
    tl_txn(3'd4, 32'h0000_0008, 32'h0, 4'hF, 4'd2, 1'b0);
    tl_txn(3'd4, 32'h0000_0008, 32'h0, 4'hF, 4'd2, 1'b0);
    c = exp_cnt;
    tl_txn(3'd4, 32'h0000_000C, 32'h0, 4'hF, 4'd2, 1'b0);
    checks++;
    if (rsp_data !== 32'd0 || c[63:32] !== 32'd0) begin
      errors++;
      $display("FAIL cnt_wrap_hi: data=%h required 00000000", rsp_data);
    end
    checks++;
    if ({rsp_op, rsp_den} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL cnt_write_denied_setup: op=%0d den=%0b required 1 0", rsp_op, rsp_den);
    end
    tl_txn(3'd0, 32'h0000_0008, 32'h5, 4'hF, 4'd2, 1'b0);
    checks++;
    if ({rsp_op, rsp_den, rsp_cor} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL cnt_write_denied: op=%0d den=%0b cor=%0b required 0 1 0", rsp_op, rsp_den, rsp_cor);
    end
  endtask

  task automatic test_random();
    logic [7:0]  offs [13];
    logic [2:0]  ops [10];
    logic [31:0] r;
    logic [2:0]  op;
    logic [3:0]  sz;
    bit          pn;
    offs = '{8'h00, 8'h04, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h40, 8'h02, 8'h13};
    ops  = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    for (int t = 0; t < 200; t++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 9)];
      sz = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      pn = ($urandom_range(0, 3) == 0);
      if (pn && exp_q.size() > 0) begin
        checks++;
        if (con_data !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_con_head t=%0d: data=%h required %h", t, con_data, exp_q[0]);
        end
      end
      tl_txn(op, {r[31:8], offs[$urandom_range(0, 12)]}, $urandom(), 4'($urandom_range(0, 15)), sz, pn);
      checks++;
      if ({rsp_op, rsp_den, rsp_data, rsp_cor, rsp_size, rsp_src} !== {exp_op, exp_den, exp_data, exp_cor, exp_size, exp_src}) begin
        errors++;
        $display("FAIL rnd_rsp t=%0d addr=%h: op=%0d den=%0b data=%h cor=%0b size=%0d src=%0d required %0d %0b %h %0b %0d %0d",
                 t, a_address, rsp_op, rsp_den, rsp_data, rsp_cor, rsp_size, rsp_src,
                 exp_op, exp_den, exp_data, exp_cor, exp_size, exp_src);
      end
      checks++;
      if ({state_o, callenv, exit_code, con_valid, a_ready, d_valid} !==
          {exp_state_o(), m_callenv, m_exit, exp_q.size() > 0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rnd_regs t=%0d: state=%h callenv=%0b exit=%h con_valid=%0b a_ready=%0b d_valid=%0b required %h %0b %h %0b 1 0",
                 t, state_o, callenv, exit_code, con_valid, a_ready, d_valid,
                 exp_state_o(), m_callenv, m_exit, exp_q.size() > 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    tl_txn(3'd0, 32'h0000_0004, 32'h77, 4'h1, 4'd0, 1'b0);
    a_opcode  = 3'd4;
    a_address = 32'h0000_0000;
    a_size    = 4'd2;
    a_valid   = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b1 || con_valid !== 1'b1 || callenv !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: d_valid=%0b con_valid=%0b callenv=%0b required 1 1 1", d_valid, con_valid, callenv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d_valid, a_ready, callenv, exit_code, con_valid, state_o} !== {1'b0, 1'b1, 1'b0, 32'd0, 1'b0, {32*SW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_mid: d_valid=%0b a_ready=%0b callenv=%0b exit=%h con_valid=%0b state=%h required 0 1 0 0 0 0",
               d_valid, a_ready, callenv, exit_code, con_valid, state_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_state_regs();
    test_console();
    test_exit();
    test_backpressure();
    test_counter();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
